imem_boot_loader: RTL and testbench

- Synthesizable program loader sitting between an external word stream and the CPU instruction-memory write port.
- Holds the CPU in stall while it streams a program into instruction memory from word address 0.
- Then releases the CPU with a one-cycle start pulse and supervises the run until the CPU's finish signal or a cycle-count watchdog expires.
- Counterpart of the bench-side memory readback: this block writes memory before execution; the bench reads data memory after it.

---
 rtl/imem_boot_loader_pkg.sv | 23 ++
 rtl/imem_watchdog_counter.sv | 45 ++++
 rtl/imem_boot_loader.sv | 144 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and default sizing for the instruction-memory boot loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_boot_loader_pkg;

  // Loader / run-supervisor states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  localparam int INSTR_W = 32;

  // Defaults shared with the CPU instruction/data memory models.
  localparam int DEFAULT_DEPTH      = 512;
  localparam int DEFAULT_AW         = 9;
  localparam int DEFAULT_MAX_CYCLES = 300;

endpackage

// File: rtl/imem_watchdog_counter.sv
// Loadable cycle counter with clear, load, enable and a terminal-count flag.
// Latency: count changes on the edge after clr/load/en; tc is combinational from the count.
// Backpressure: none; counts whenever en is high.
module imem_watchdog_counter #(
  parameter int W    = 9,
  parameter int TERM = 299
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  localparam logic [W-1:0] TERM_V = W'(TERM);
  localparam logic [W-1:0] ONE    = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load, load beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TERM_V);

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a program into instruction memory from word 0, then starts and supervises the CPU.
// Latency: beat-to-write combinational; last beat to cpu_start 1 cycle; cpu_finish to done 1 cycle.
// Backpressure: in_ready is high only in LOAD; every valid beat in LOAD is accepted and written.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AW         = DEFAULT_AW,
  parameter int MAX_CYCLES = DEFAULT_MAX_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_data,
  input  logic               in_last,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               cpu_start,
  input  logic               cpu_finish,
  output logic [AW:0]        loaded_words,
  output logic               done,
  output logic               overflow,
  output logic               timeout
);

  localparam int          CW        = $clog2(MAX_CYCLES + 1);
  localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] WORD_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] NO_LOAD = '0;

  state_e      state_q, state_d;
  logic [AW:0] wcnt_q, wcnt_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        tmo_q, tmo_d;
  logic        wd_clr, wd_en, wd_tc;

  // Run-time watchdog: cleared in START, counts every RUN cycle.
  imem_watchdog_counter #(
    .W    (CW),
    .TERM (MAX_CYCLES - 1)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (wd_clr),
    .load     (1'b0),
    .load_val (NO_LOAD),
    .en       (wd_en),
    .tc       (wd_tc)
  );

  // Next-state, handshake and CPU control decode.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
    in_ready  = 1'b0;
    cpu_hold  = 1'b1;
    cpu_start = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LOAD;
          wcnt_d  = '0;
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wcnt_d = wcnt_q + WORD_ONE;
          if (in_last) begin
            state_d = S_START;
          end else if (wcnt_q == LAST_ADDR) begin
            // Memory is full and the stream wants more: the last word is
            // still written, then the load is abandoned.
            state_d = S_ERROR;
            ovf_d   = 1'b1;
          end
        end
      end
      S_START: begin
        cpu_hold  = 1'b0;
        cpu_start = 1'b1;
        wd_clr    = 1'b1;
        state_d   = S_RUN;
      end
      S_RUN: begin
        cpu_hold = 1'b0;
        wd_en    = 1'b1;
        // A finish in the watchdog's terminal cycle still counts as success.
        if (cpu_finish) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (wd_tc) begin
          state_d = S_ERROR;
          tmo_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and status registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  // The word counter is one bit wider than the address so it never wraps;
  // it doubles as the loaded-word count.
  assign mem_we       = in_ready & in_valid;
  assign mem_addr     = wcnt_q[AW-1:0];
  assign mem_wdata    = in_data;
  assign loaded_words = wcnt_q;
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign timeout      = tmo_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed, table-driven bench for imem_boot_loader: load, run, watchdog, overflow and reset cases.
module tb_imem_boot_loader;

  localparam int          DEPTH = 512;
  localparam int          AW    = 9;
  localparam int          MAXC  = 300;
  localparam logic [31:0] BASE  = 32'h2008_0005;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, cpu_finish;
  logic [31:0] in_data, mem_wdata;
  logic        in_ready, mem_we, cpu_hold, cpu_start, done, overflow, timeout;
  logic [AW-1:0] mem_addr;
  logic [AW:0]   loaded_words;

  int checks = 0;
  int errors = 0;

  // Write / pulse monitor (only this process writes these).
  int wa_q[$];
  int wd_q[$];
  int start_pulses = 0;

  imem_boot_loader #(.DEPTH(DEPTH), .AW(AW), .MAX_CYCLES(MAXC)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .cpu_start    (cpu_start),
    .cpu_finish   (cpu_finish),
    .loaded_words (loaded_words),
    .done         (done),
    .overflow     (overflow),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(int'(mem_wdata));
    end
    if (cpu_start) start_pulses++;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish, required finish before 1 ms");
    $fatal(1);
  end

  typedef struct {
    string nm;
    int    n;        // words streamed
    bit    toggle;   // idle cycle between beats
    bit    last;     // in_last on final beat
    int    fin_at;   // RUN cycle index with cpu_finish=1 (-1 none)
    int    start_at; // RUN cycle index with a stray start pulse (-1 none)
    bit    e_done;
    bit    e_tmo;
    bit    e_ovf;
    int    e_run;    // expected number of RUN cycles
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_beats(input int n, input bit toggle, input bit last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = BASE + 32'(i);
      in_last  = last && (i == n - 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (toggle && i != n - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic run_case(input vec_t v);
    int base, sp0, run_cyc, bad;
    base = wa_q.size();
    sp0  = start_pulses;
    do_start();
    @(negedge clk);
    chk({v.nm, ".load_ready"}, int'(in_ready), 1);
    chk({v.nm, ".load_clear"}, int'({done, overflow, timeout}), 0);
    chk({v.nm, ".load_words0"}, int'(loaded_words), 0);
    @(posedge clk); #1;
    send_beats(v.n, v.toggle, v.last);
    @(negedge clk);
    if (v.last) begin
      // One cycle after the last beat: START.
      chk({v.nm, ".cpu_start"}, int'(cpu_start), 1);
      chk({v.nm, ".start_hold"}, int'(cpu_hold), 0);
      chk({v.nm, ".loaded"}, int'(loaded_words), v.n);
      @(posedge clk); #1;
      run_cyc = 0;
      while (cpu_hold == 1'b0 && run_cyc < MAXC + 10) begin
        cpu_finish = (run_cyc == v.fin_at);
        start      = (run_cyc == v.start_at);
        @(posedge clk); #1;
        cpu_finish = 1'b0;
        start      = 1'b0;
        run_cyc++;
      end
      chk({v.nm, ".run_cycles"}, run_cyc, v.e_run);
      @(negedge clk);
    end
    chk({v.nm, ".done"}, int'(done), int'(v.e_done));
    chk({v.nm, ".timeout"}, int'(timeout), int'(v.e_tmo));
    chk({v.nm, ".overflow"}, int'(overflow), int'(v.e_ovf));
    chk({v.nm, ".end_hold"}, int'(cpu_hold), 1);
    chk({v.nm, ".end_ready"}, int'(in_ready), 0);
    chk({v.nm, ".end_loaded"}, int'(loaded_words), v.n);
    chk({v.nm, ".start_pulses"}, start_pulses - sp0, v.last ? 1 : 0);
    chk({v.nm, ".writes"}, wa_q.size() - base, v.n);
    bad = 0;
    for (int i = 0; i < v.n && base + i < wa_q.size(); i++) begin
      if (wa_q[base + i] != i || wd_q[base + i] != int'(BASE + 32'(i))) bad++;
    end
    chk({v.nm, ".write_seq_bad"}, bad, 0);
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = '0; cpu_finish = 1'b0;

    vecs[0] = '{"four_words",  4,   1'b0, 1'b1, 20,  -1, 1'b1, 1'b0, 1'b0, 21};
    vecs[1] = '{"toggle_valid", 5,  1'b1, 1'b1, 3,   -1, 1'b1, 1'b0, 1'b0, 4};
    vecs[2] = '{"watchdog",    2,   1'b0, 1'b1, -1,  5,  1'b0, 1'b1, 1'b0, MAXC};
    vecs[3] = '{"finish_at_tc", 3,  1'b0, 1'b1, MAXC - 1, -1, 1'b1, 1'b0, 1'b0, MAXC};
    vecs[4] = '{"one_word",    1,   1'b0, 1'b1, 0,   -1, 1'b1, 1'b0, 1'b0, 1};
    vecs[5] = '{"overflow",    DEPTH, 1'b0, 1'b0, -1, -1, 1'b0, 1'b0, 1'b1, 0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.cpu_hold", int'(cpu_hold), 1);
    chk("reset.outputs", int'({in_ready, mem_we, cpu_start, done, overflow, timeout}), 0);
    chk("reset.loaded", int'(loaded_words), 0);

    foreach (vecs[k]) run_case(vecs[k]);

    // Reset in the middle of a load (after three beats).
    do_start();
    @(posedge clk); #1;
    send_beats(3, 1'b0, 1'b0);
    chk("midload.loaded_before", int'(loaded_words), 3);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("midload_rst.hold", int'(cpu_hold), 1);
    chk("midload_rst.ready", int'(in_ready), 0);
    chk("midload_rst.flags", int'({done, overflow, timeout}), 0);
    chk("midload_rst.loaded", int'(loaded_words), 0);
    // IDLE ignores stream beats.
    base = wa_q.size();
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    chk("idle.no_write", wa_q.size() - base, 0);

    // Reset in the middle of a run.
    do_start();
    @(posedge clk); #1;
    send_beats(2, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midrun.hold_before", int'(cpu_hold), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrun_rst.hold", int'(cpu_hold), 1);
    chk("midrun_rst.flags", int'({cpu_start, done, overflow, timeout}), 0);
    chk("midrun_rst.loaded", int'(loaded_words), 0);

    // A fresh start reloads from address 0.
    run_case('{"reload", 3, 1'b0, 1'b1, 5, -1, 1'b1, 1'b0, 1'b0, 6});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
